ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DataWidth, default 64, operand/result width (RV64).
REQ-002 Parameter IterCycles, default 64, iterations per multiply/divide.
REQ-003 Clocking: one clock; reset is synchronous and active-high (ports Clk, Rst).
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Rst  input  1  synchronous active-high reset.
REQ-006 OpCodeIn  input  7  opcode from ID/EX stage register.
REQ-007 Funct3In  input  3  funct3 from ID/EX stage register.
REQ-008 Funct7In  input  7  funct7 from ID/EX stage register.
REQ-009 Rs1ReadDataIn  input  64  operand A.
REQ-010 Rs2ReadDataIn  input  64  operand B.
REQ-011 RdAddrIn  input  5  destination register.
REQ-012 FlushIn  input  1  abort current operation.
REQ-013 StallReq  output  1  hold ID/EX and earlier stages.
REQ-014 ResultValid  output  1  one-cycle strobe, ResultOut/RdAddrOut valid.
REQ-015 ResultOut  output  64  M-extension result.
REQ-016 RdAddrOut  output  5  destination of ResultOut.

Function
REQ-017 M-op detected when Funct7In==7'b0000001 and OpCodeIn is 7'b0110011 (64-bit) or 7'b0111011 (W form); Funct3In selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
REQ-018 States IDLE, BUSY, DONE; Rst or FlushIn forces IDLE next cycle.
REQ-019 IDLE: M-op present -> latch operands, Funct3, W flag, RdAddrIn; go BUSY (or DONE via fast path, REQ-024).
REQ-020 StallReq combinationally 1 in IDLE with M-op present and throughout BUSY; 0 in DONE and otherwise.
REQ-021 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide); iteration counter 0..IterCycles-1; last step -> DONE.
REQ-022 DONE: ResultValid=1 for exactly one cycle; always -> IDLE; no acceptance in DONE (inputs still hold the completed instruction).
REQ-023 Latency: ResultValid asserted IterCycles+1 cycles after the accepting edge (65 at default); back-to-back M-ops accepted the cycle after DONE.
REQ-024 Fast path, DONE on the cycle after acceptance: divisor zero -> DIV/DIVU = all ones, REM/REMU = dividend; signed overflow (MIN / -1) -> DIV = MIN, REM = 0.
REQ-025 MUL returns low 64 bits of 128-bit product; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned return high 64 bits.
REQ-026 Signed divide: operate on magnitudes; quotient negative when signs differ; remainder takes dividend sign.
REQ-027 W forms: operands are low 32 bits (sign- or zero-extended per op); result is 32-bit value sign-extended to 64; overflow/zero cases use 32-bit MIN/all-ones then sign-extend.
REQ-028 FlushIn in any state: no ResultValid for the aborted op; StallReq 0 the same cycle.
REQ-029 FlushIn and M-op present in IDLE simultaneously: flush wins, nothing accepted.
REQ-030 ResultOut/RdAddrOut hold last value outside DONE; only ResultValid qualifies them.

Reset
REQ-031 Rst=1 at a rising edge: state IDLE, counter 0, ResultValid 0, ResultOut 0, RdAddrOut 0; StallReq 0 while Rst held.
REQ-032 Rst mid-BUSY discards the operation; no ResultValid follows.

Verification
REQ-033 MUL rs1=7, rs2=-3, rd=5 -> StallReq high 65 cycles, ResultValid at cycle 65, ResultOut=0xFFFFFFFFFFFFFFEB, RdAddrOut=5.
REQ-034 MULHU 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> ResultOut=0xFFFFFFFFFFFFFFFE.
REQ-035 DIV -7/2 -> -3 (0xFFFFFFFFFFFFFFFD); REM -7/2 -> -1; DIVU x/0 -> all ones at cycle 1; REM 0x8000000000000000 / -1 -> 0 at cycle 1.
REQ-036 DIVW 0x00000000_80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000; MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE.
REQ-037 FlushIn at BUSY cycle 10 -> IDLE next cycle, StallReq 0, no ResultValid; next M-op completes normally.
REQ-038 Rst at BUSY cycle 30 -> all outputs 0, no ResultValid; two back-to-back M-ops after reset each complete with correct result, second accepted cycle after first DONE.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64 M-extension execute unit (radix-2 shift-add multiply, restoring divide)
module ex_muldiv #(
  parameter int DataWidth  = 64,
  parameter int IterCycles = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [6:0]           OpCodeIn,
  input  logic [2:0]           Funct3In,
  input  logic [6:0]           Funct7In,
  input  logic [DataWidth-1:0] Rs1ReadDataIn,
  input  logic [DataWidth-1:0] Rs2ReadDataIn,
  input  logic [4:0]           RdAddrIn,
  input  logic                 FlushIn,
  output logic                 StallReq,
  output logic                 ResultValid,
  output logic [DataWidth-1:0] ResultOut,
  output logic [4:0]           RdAddrOut
);
  localparam int W  = DataWidth;
  localparam int H  = W / 2;
  localparam int CW = $clog2(IterCycles + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [2:0]     f3_q, f3_d;
  logic           w_q, w_d, an_q, an_d, bn_q, bn_d;
  logic [4:0]     rd_q, rd_d, rdo_q, rdo_d;
  logic           m_op, is_w, a_sg, b_sg, a_n, b_n, dz, ovf, fast, ge;
  logic [W-1:0]   a_x, b_x, a_m, b_m, min_v, fast_r, s_hi, s_lo, quo, rem, fin_r;
  logic [W:0]     sum, sh;
  logic [2*W-1:0] prod;
  // W-form results are the low half sign-extended to full width
  function automatic logic [W-1:0] fmt(input logic wf, input logic [W-1:0] v);
    return wf ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction
  // decode the incoming instruction, extend operands and resolve the divide fast path
  always_comb begin
    m_op   = Funct7In == 7'b0000001 && (OpCodeIn == 7'b0110011 || OpCodeIn == 7'b0111011);
    is_w   = OpCodeIn == 7'b0111011;
    a_sg   = Funct3In == 3'd1 || Funct3In == 3'd2 || (Funct3In[2] && !Funct3In[0]);
    b_sg   = Funct3In == 3'd1 || (Funct3In[2] && !Funct3In[0]);
    a_x    = is_w ? {{H{a_sg & Rs1ReadDataIn[H-1]}}, Rs1ReadDataIn[H-1:0]} : Rs1ReadDataIn;
    b_x    = is_w ? {{H{b_sg & Rs2ReadDataIn[H-1]}}, Rs2ReadDataIn[H-1:0]} : Rs2ReadDataIn;
    a_n    = a_sg & a_x[W-1];
    b_n    = b_sg & b_x[W-1];
    a_m    = a_n ? -a_x : a_x;
    b_m    = b_n ? -b_x : b_x;
    min_v  = is_w ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    dz     = b_x == '0;
    ovf    = Funct3In[2] & ~Funct3In[0] & (a_x == min_v) & (b_x == '1);
    fast   = Funct3In[2] & (dz | ovf);
    fast_r = fmt(is_w, dz ? (Funct3In[1] ? a_x : '1) : (Funct3In[1] ? '0 : min_v));
  end
  // one radix-2 step on magnitudes plus sign fix-up of the would-be final result
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh    = {hi_q, lo_q[W-1]};
    ge    = sh >= {1'b0, b_q};
    s_hi  = f3_q[2] ? (ge ? sh[W-1:0] - b_q : sh[W-1:0]) : sum[W:1];
    s_lo  = f3_q[2] ? {lo_q[W-2:0], ge} : {sum[0], lo_q[W-1:1]};
    prod  = (an_q ^ bn_q) ? -{s_hi, s_lo} : {s_hi, s_lo};
    quo   = (an_q ^ bn_q) ? -s_lo : s_lo;
    rem   = an_q ? -s_hi : s_hi;
    fin_r = fmt(w_q, f3_q[2] ? (f3_q[1] ? rem : quo) : (f3_q[1:0] == 2'd0 ? prod[W-1:0] : prod[2*W-1:W]));
  end
  // next-state: flush wins, accept only in IDLE, results land in the output regs on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    f3_d    = f3_q;
    w_d     = w_q;
    an_d    = an_q;
    bn_d    = bn_q;
    rd_d    = rd_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    if (FlushIn) begin
      state_d = IDLE;
    end else if (state_q == IDLE && m_op) begin
      state_d = fast ? DONE : BUSY;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = a_m;
      b_d     = b_m;
      f3_d    = Funct3In;
      w_d     = is_w;
      an_d    = a_n;
      bn_d    = b_n;
      rd_d    = RdAddrIn;
      res_d   = fast ? fast_r : res_q;
      rdo_d   = fast ? RdAddrIn : rdo_q;
    end else if (state_q == BUSY) begin
      hi_d  = s_hi;
      lo_d  = s_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(IterCycles - 1)) begin
        state_d = DONE;
        res_d   = fin_r;
        rdo_d   = rd_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      w_q     <= 1'b0;
      an_q    <= 1'b0;
      bn_q    <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      w_q     <= w_d;
      an_q    <= an_d;
      bn_q    <= bn_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end
  assign StallReq    = !Rst && !FlushIn && ((state_q == IDLE && m_op) || state_q == BUSY);
  assign ResultValid = state_q == DONE && !FlushIn;
  assign ResultOut   = res_q;
  assign RdAddrOut   = rdo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed + random scoreboard bench for ex_muldiv
module tb_ex_muldiv;
  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPW = 7'b0111011;
  localparam logic [6:0] F7M = 7'b0000001;
  logic        Clk = 1'b0, Rst, FlushIn, StallReq, ResultValid;
  logic [6:0]  OpCodeIn, Funct7In;
  logic [2:0]  Funct3In;
  logic [63:0] Rs1ReadDataIn, Rs2ReadDataIn, ResultOut;
  logic [4:0]  RdAddrIn, RdAddrOut;
  typedef struct {logic [63:0] res; logic [4:0] rd;} exp_t;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [63:0] last_res = '0;

  ex_muldiv dut (
    .Clk(Clk), .Rst(Rst), .OpCodeIn(OpCodeIn), .Funct3In(Funct3In), .Funct7In(Funct7In),
    .Rs1ReadDataIn(Rs1ReadDataIn), .Rs2ReadDataIn(Rs2ReadDataIn), .RdAddrIn(RdAddrIn),
    .FlushIn(FlushIn), .StallReq(StallReq), .ResultValid(ResultValid),
    .ResultOut(ResultOut), .RdAddrOut(RdAddrOut)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb2;
    logic signed [31:0] sa32, sb32;
    logic [127:0]       p;
    logic [31:0]        r32;
    logic [63:0]        r;
    sa = a; sb2 = b; sa32 = a[31:0]; sb32 = b[31:0];
    r32 = '0; r = '0; p = '0;
    if (w) begin
      case (f3)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: if (b[31:0] == 0) r32 = '1;
              else if (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) r32 = 32'h80000000;
              else r32 = sa32 / sb32;
        3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 0) r32 = a[31:0];
              else if (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) r32 = '0;
              else r32 = sa32 % sb32;
        3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 64'h8000000000000000 && b == '1) r = a;
            else r = sa / sb2;
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 64'h8000000000000000 && b == '1) r = '0;
            else r = sa % sb2;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    if (!f3[2]) return 1'b0;
    if (w) return b[31:0] == 0 || (!f3[0] && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
    return b == 0 || (!f3[0] && a == 64'h8000000000000000 && b == '1);
  endfunction

  task automatic present(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    OpCodeIn = w ? OPW : OP; Funct7In = F7M; Funct3In = f3;
    Rs1ReadDataIn = a; Rs2ReadDataIn = b; RdAddrIn = rd;
  endtask

  task automatic clear();
    OpCodeIn = '0; Funct7In = '0; Funct3In = '0;
    Rs1ReadDataIn = '0; Rs2ReadDataIn = '0; RdAddrIn = '0;
  endtask

  task automatic do_op(input string tag, input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    int   cyc, stalls, lat;
    bit   got;
    exp_t e;
    lat = is_fast(f3, w, a, b) ? 1 : 65;
    e.res = model(f3, w, a, b); e.rd = rd;
    sb.push_back(e);
    present(w, f3, a, b, rd);
    cyc = 0; stalls = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge Clk);
      if (StallReq) stalls++;
      if (cyc == 0) check({tag, "_nv0"}, 64'(ResultValid), 64'd0);
      if (cyc == 1 && lat > 1) check({tag, "_hold"}, ResultOut, last_res);
      if (ResultValid) begin
        got = 1;
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_stall"}, 64'(stalls), 64'(lat));
        check({tag, "_sbq"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, "_res"}, ResultOut, e.res);
          check({tag, "_rd"}, 64'(RdAddrOut), 64'(e.rd));
          last_res = e.res;
        end
      end
      @(posedge Clk); #1;
      cyc++;
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    clear();
  endtask

  task automatic quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge Clk);
      if (ResultValid) pulses++;
    end
    @(posedge Clk); #1;
    check(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    Rst = 1'b1; FlushIn = 1'b0;
    present(1'b0, 3'd0, 64'd7, 64'd3, 5'd1);
    @(negedge Clk);
    check("rst_stall", 64'(StallReq), 64'd0);
    repeat (2) @(posedge Clk);
    #1; clear();
    @(negedge Clk);
    check("rst_valid", 64'(ResultValid), 64'd0);
    check("rst_res", ResultOut, 64'd0);
    check("rst_rd", 64'(RdAddrOut), 64'd0);
    @(posedge Clk); #1; Rst = 1'b0;

    do_op("mul", 1'b0, 3'd0, 64'd7, -64'sd3, 5'd5);
    do_op("mulhu", 1'b0, 3'd3, '1, '1, 5'd6);
    do_op("mulh", 1'b0, 3'd1, -64'sd2, 64'd3, 5'd7);
    do_op("mulhsu", 1'b0, 3'd2, -64'sd1, 64'd2, 5'd8);
    do_op("div", 1'b0, 3'd4, -64'sd7, 64'd2, 5'd9);
    do_op("rem", 1'b0, 3'd6, -64'sd7, 64'd2, 5'd10);
    do_op("divu0", 1'b0, 3'd5, 64'h1234, 64'd0, 5'd11);
    do_op("removf", 1'b0, 3'd6, 64'h8000000000000000, '1, 5'd12);
    do_op("divovf", 1'b0, 3'd4, 64'h8000000000000000, '1, 5'd13);
    do_op("rem0", 1'b0, 3'd6, -64'sd5, 64'd0, 5'd14);
    do_op("remu", 1'b0, 3'd7, 64'd100, 64'd7, 5'd15);
    do_op("divw", 1'b1, 3'd4, 64'h0000000080000000, 64'h00000000FFFFFFFF, 5'd16);
    do_op("mulw", 1'b1, 3'd0, 64'h000000007FFFFFFF, 64'd2, 5'd17);
    do_op("remw", 1'b1, 3'd6, 64'hABCD0000FFFFFFF9, 64'd4, 5'd18);
    do_op("divuw", 1'b1, 3'd5, 64'h00000000F0000000, 64'd16, 5'd19);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] f;
      logic       w;
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if (w && !f[2]) f = 3'd0;
      do_op($sformatf("rnd%0d", i), w, f, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(1, 31)));
    end

    present(1'b0, 3'd0, 64'd5, 64'd9, 5'd3);
    repeat (11) @(posedge Clk);
    #1; FlushIn = 1'b1;
    @(negedge Clk);
    check("flush_stall", 64'(StallReq), 64'd0);
    check("flush_valid", 64'(ResultValid), 64'd0);
    @(posedge Clk); #1; FlushIn = 1'b0; clear();
    @(negedge Clk);
    check("flush_idle", 64'(StallReq), 64'd0);
    quiet("flush_nv", 80);
    do_op("post_flush", 1'b0, 3'd0, 64'd11, 64'd13, 5'd4);

    present(1'b0, 3'd4, 64'd100, 64'd3, 5'd2);
    FlushIn = 1'b1;
    @(negedge Clk);
    check("flacc_stall", 64'(StallReq), 64'd0);
    @(posedge Clk); #1; FlushIn = 1'b0; clear();
    @(negedge Clk);
    check("flacc_idle", 64'(StallReq), 64'd0);
    quiet("flacc_nv", 80);

    present(1'b0, 3'd1, 64'd12345, 64'd678, 5'd9);
    repeat (31) @(posedge Clk);
    #1; Rst = 1'b1; clear();
    @(negedge Clk);
    check("rstb_stall", 64'(StallReq), 64'd0);
    @(posedge Clk); #1; Rst = 1'b0; last_res = '0;
    @(negedge Clk);
    check("rstb_valid", 64'(ResultValid), 64'd0);
    check("rstb_res", ResultOut, 64'd0);
    check("rstb_rd", 64'(RdAddrOut), 64'd0);
    check("rstb_stall2", 64'(StallReq), 64'd0);
    quiet("rstb_nv", 80);
    do_op("b2b_a", 1'b0, 3'd0, 64'hDEADBEEF, 64'h1000, 5'd20);
    do_op("b2b_b", 1'b0, 3'd5, 64'hFFFF0000, 64'd255, 5'd21);
    quiet("tail_nv", 10);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
